// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin arbiter feeding the 8-bit TX AXI-stream of the MAC/FIFO wrapper.
// Optional length limiting with truncation is enabled by defining ETH_TX_ARB_MAXLEN_EN.
module eth_tx_frame_arbiter #(
  parameter int PORTS         = 4,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int LEN_WIDTH     = 16,
  parameter int IDX_WIDTH     = $clog2(PORTS)
) (
  input  logic                   logic_clk,
  input  logic                   logic_rst,
  input  logic [PORTS*8-1:0]     s_axis_tdata,
  input  logic [PORTS-1:0]       s_axis_tvalid,
  output logic [PORTS-1:0]       s_axis_tready,
  input  logic [PORTS-1:0]       s_axis_tlast,
  input  logic [PORTS-1:0]       s_axis_tuser,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   grant_active,
  output logic [IDX_WIDTH-1:0]   grant_index,
  output logic                   frame_done,
  output logic [IDX_WIDTH-1:0]   frame_done_index,
  output logic                   truncated
);

`ifdef ETH_TX_ARB_MAXLEN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DROP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

  // The in-frame counter must be able to represent the frame length limit.
  if (MAX_FRAME_LEN > (2 ** LEN_WIDTH) - 1) begin : g_len_check
    $error("LEN_WIDTH too narrow for MAX_FRAME_LEN");
  end

  state_t                 state_reg, state_next;
  logic [IDX_WIDTH-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IDX_WIDTH-1:0]   grant_index_reg, grant_index_next;
  logic [LEN_WIDTH-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [7:0]             out_data_reg;
  logic                   out_valid_reg, out_last_reg, out_user_reg;
  logic                   frame_done_reg;
  logic [IDX_WIDTH-1:0]   frame_done_index_reg;

  logic                   out_free;
  logic                   xfer;
  logic                   load;
  logic                   load_last, load_user;
  logic                   done_next;
  logic                   arb_found;
  logic [IDX_WIDTH-1:0]   arb_index;
  logic [IDX_WIDTH-1:0]   grant_inc;

  logic [7:0]             port_data [PORTS];
  logic [IDX_WIDTH-1:0]   cand_idx [PORTS];
  logic                   sel_tvalid, sel_tlast, sel_tuser;
  logic [7:0]             sel_tdata;

  assign out_free = !out_valid_reg || m_axis_tready;

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port
      logic [IDX_WIDTH:0] rr_sum;
      assign port_data[gi] = s_axis_tdata[gi*8 +: 8];
      // Candidate gi of the round-robin scan: (rr_ptr + gi) mod PORTS.
      assign rr_sum = {1'b0, rr_ptr_reg} + (IDX_WIDTH+1)'(gi);
      assign cand_idx[gi] = (rr_sum >= (IDX_WIDTH+1)'(PORTS))
                            ? IDX_WIDTH'(rr_sum - (IDX_WIDTH+1)'(PORTS))
                            : IDX_WIDTH'(rr_sum);
`ifdef ETH_TX_ARB_MAXLEN_EN
      assign s_axis_tready[gi] = (grant_index_reg == IDX_WIDTH'(gi)) &&
                                 (((state_reg == GRANT) && out_free) || (state_reg == DROP));
`else
      assign s_axis_tready[gi] = (grant_index_reg == IDX_WIDTH'(gi)) &&
                                 (state_reg == GRANT) && out_free;
`endif
    end
  endgenerate

  assign sel_tvalid = s_axis_tvalid[grant_index_reg];
  assign sel_tlast  = s_axis_tlast[grant_index_reg];
  assign sel_tuser  = s_axis_tuser[grant_index_reg];
  assign sel_tdata  = port_data[grant_index_reg];
  assign xfer       = (state_reg == GRANT) && out_free && sel_tvalid;
  assign grant_inc  = (grant_index_reg == IDX_WIDTH'(PORTS - 1)) ? '0 : grant_index_reg + 1'b1;

  // Scan from the farthest candidate back to rr_ptr so the nearest requester wins.
  always_comb begin
    arb_found = 1'b0;
    arb_index = rr_ptr_reg;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (s_axis_tvalid[cand_idx[k]]) begin
        arb_found = 1'b1;
        arb_index = cand_idx[k];
      end
    end
  end

`ifdef ETH_TX_ARB_MAXLEN_EN
  logic trunc_next;
  logic truncated_reg;
`endif

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    grant_index_next = grant_index_reg;
    byte_cnt_next    = byte_cnt_reg;
    load             = 1'b0;
    load_last        = sel_tlast;
    load_user        = sel_tuser;
    done_next        = 1'b0;
`ifdef ETH_TX_ARB_MAXLEN_EN
    trunc_next       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (arb_found) begin
          grant_index_next = arb_index;
          byte_cnt_next    = '0;
          state_next       = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          load = 1'b1;
          if (byte_cnt_reg != '1) byte_cnt_next = byte_cnt_reg + 1'b1;
          if (sel_tlast) begin
            done_next   = 1'b1;
            rr_ptr_next = grant_inc;
            state_next  = IDLE;
          end
`ifdef ETH_TX_ARB_MAXLEN_EN
          else if (byte_cnt_reg == LEN_WIDTH'(MAX_FRAME_LEN - 1)) begin
            // Close the frame early as bad; the rest of the input frame is dropped.
            load_last  = 1'b1;
            load_user  = 1'b1;
            done_next  = 1'b1;
            trunc_next = 1'b1;
            state_next = DROP;
          end
`endif
        end
      end
`ifdef ETH_TX_ARB_MAXLEN_EN
      DROP: begin
        if (sel_tvalid && sel_tlast) begin
          rr_ptr_next = grant_inc;
          state_next  = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state_reg            <= IDLE;
      rr_ptr_reg           <= '0;
      grant_index_reg      <= '0;
      byte_cnt_reg         <= '0;
      out_data_reg         <= '0;
      out_valid_reg        <= 1'b0;
      out_last_reg         <= 1'b0;
      out_user_reg         <= 1'b0;
      frame_done_reg       <= 1'b0;
      frame_done_index_reg <= '0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      grant_index_reg <= grant_index_next;
      byte_cnt_reg    <= byte_cnt_next;
      if (load) begin
        out_data_reg  <= sel_tdata;
        out_last_reg  <= load_last;
        out_user_reg  <= load_user;
        out_valid_reg <= 1'b1;
      end else if (out_free) begin
        out_valid_reg <= 1'b0;
      end
      frame_done_reg <= done_next;
      if (done_next) frame_done_index_reg <= grant_index_reg;
    end
  end

`ifdef ETH_TX_ARB_MAXLEN_EN
  always_ff @(posedge logic_clk) begin
    if (logic_rst) truncated_reg <= 1'b0;
    else           truncated_reg <= trunc_next;
  end
  assign truncated = truncated_reg;
`else
  assign truncated = 1'b0;
`endif

  assign m_axis_tdata     = out_data_reg;
  assign m_axis_tvalid    = out_valid_reg;
  assign m_axis_tlast     = out_last_reg;
  assign m_axis_tuser     = out_user_reg;
  assign grant_active     = (state_reg != IDLE);
  assign grant_index      = grant_index_reg;
  assign frame_done       = frame_done_reg;
  assign frame_done_index = frame_done_index_reg;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Scoreboard bench for eth_tx_frame_arbiter: directed frames in, expected beats queued, monitor compares.
module tb_eth_tx_frame_arbiter;
  localparam int PORTS = 4;
  localparam int IDXW  = 2;
`ifdef ETH_TX_ARB_MAXLEN_EN
  localparam int MAXLEN = 16;
`else
  localparam int MAXLEN = 1522;
`endif

  logic               clk;
  logic               rst;
  logic [PORTS*8-1:0] s_axis_tdata;
  logic [PORTS-1:0]   s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [7:0]         m_axis_tdata;
  logic               m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic               grant_active, frame_done, truncated;
  logic [IDXW-1:0]    grant_index, frame_done_index;

  logic [7:0] src_data  [PORTS];
  logic       src_valid [PORTS];
  logic       src_last  [PORTS];
  logic       src_user  [PORTS];

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t exp_q[$];
  int    fd_q[$];
  int    trunc_exp = 0;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    last_cyc = 0;
  bit    gap_check_en = 0;
  bit    gap_armed = 0;
  bit    stall_check_en = 0;
  bit    toggle_en = 0;

  eth_tx_frame_arbiter #(.PORTS(PORTS), .MAX_FRAME_LEN(MAXLEN), .LEN_WIDTH(16), .IDX_WIDTH(IDXW)) dut (
    .logic_clk(clk), .logic_rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .grant_active(grant_active), .grant_index(grant_index),
    .frame_done(frame_done), .frame_done_index(frame_done_index), .truncated(truncated)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int k = 0; k < PORTS; k++) begin
      s_axis_tdata[k*8 +: 8] = src_data[k];
      s_axis_tvalid[k]       = src_valid[k];
      s_axis_tlast[k]        = src_last[k];
      s_axis_tuser[k]        = src_user[k];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output ready: held high, or toggling every cycle while toggle_en is set.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) m_axis_tready = ~m_axis_tready;
      else           m_axis_tready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake and on every status pulse.
  initial begin
    beat_t e;
    int    idx;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {23'd0, m_axis_tdata, m_axis_tlast}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("beat data=%02h last=%0b user=%0b (exp %02h/%0b/%0b)",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
          if (gap_armed) begin
            check("frame_gap", cyc - last_cyc, 2);
            gap_armed = 0;
          end
          check("beat_data", {24'd0, m_axis_tdata}, {24'd0, e.data});
          check("beat_last", {31'd0, m_axis_tlast}, {31'd0, e.last});
          check("beat_user", {31'd0, m_axis_tuser}, {31'd0, e.user});
          if (e.last && gap_check_en) begin
            last_cyc  = cyc;
            gap_armed = 1;
          end
        end
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          check("unexpected_frame_done", {30'd0, frame_done_index}, 32'hFFFF_FFFF);
        end else begin
          idx = fd_q.pop_front();
          $display("frame_done index=%0d (exp %0d)", frame_done_index, idx);
          check("frame_done_index", {30'd0, frame_done_index}, idx);
        end
      end
      if (truncated) begin
        check("truncated_expected", (trunc_exp > 0) ? 32'd1 : 32'd0, 32'd1);
        if (trunc_exp > 0) trunc_exp--;
      end
      if (stall_check_en && m_axis_tvalid && !m_axis_tready)
        check("tready_while_stalled", {28'd0, s_axis_tready}, 32'd0);
    end
  end

  // Presents beats 0..nsend-1 of a len-byte frame on port p, one handshake each.
  task automatic send_frame(input int p, input int len, input int nsend,
                            input logic [7:0] base, input logic user_last);
    int n;
    for (int i = 0; i < nsend; i++) begin
      src_data[p]  = base + 8'(i);
      src_last[p]  = (i == len - 1);
      src_user[p]  = user_last && (i == len - 1);
      src_valid[p] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_axis_tready[p] && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!s_axis_tready[p]) begin
        check("handshake_timeout", p, 32'hFFFF_FFFF);
        src_valid[p] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    src_valid[p] = 1'b0;
    src_last[p]  = 1'b0;
    src_user[p]  = 1'b0;
  endtask

  task automatic push_frame(input int p, input int len, input logic [7:0] base,
                            input logic user_last);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{data: base + 8'(i), last: (i == len - 1), user: user_last && (i == len - 1)});
    fd_q.push_back(p);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid || grant_active) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int k = 0; k < PORTS; k++) begin
      src_data[k]  = 8'h00;
      src_valid[k] = 1'b0;
      src_last[k]  = 1'b0;
      src_user[k]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("rst_m_tdata", {24'd0, m_axis_tdata}, 0);
    check("rst_m_tlast_tuser", {30'd0, m_axis_tlast, m_axis_tuser}, 0);
    check("rst_grant_active", {31'd0, grant_active}, 0);
    check("rst_grant_index", {30'd0, grant_index}, 0);
    check("rst_pulses", {30'd0, frame_done, truncated}, 0);
    check("rst_s_tready", {28'd0, s_axis_tready}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single 64-byte frame on port 0, two cycles to first output beat.
    push_frame(0, 64, 8'h00, 1'b0);
    fork
      send_frame(0, 64, 64, 8'h00, 1'b0);
      begin
        n = 0;
        while (!m_axis_tvalid && n < 10) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("t1_first_beat_latency", n, 2);
      end
    join
    wait_idle("t1_idle");

    // 2: move rr_ptr to 2 with a one-beat frame on port 1, then all four ports contend.
    push_frame(1, 1, 8'h50, 1'b0);
    send_frame(1, 1, 1, 8'h50, 1'b0);
    wait_idle("t2_pre_idle");
    gap_check_en = 1;
    push_frame(2, 4, 8'h80, 1'b0);
    push_frame(3, 4, 8'hC0, 1'b0);
    push_frame(0, 4, 8'h00, 1'b0);
    push_frame(1, 4, 8'h40, 1'b0);
    fork
      send_frame(0, 4, 4, 8'h00, 1'b0);
      send_frame(1, 4, 4, 8'h40, 1'b0);
      send_frame(2, 4, 4, 8'h80, 1'b0);
      send_frame(3, 4, 4, 8'hC0, 1'b0);
    join
    wait_idle("t2_idle");
    gap_check_en = 0;
    gap_armed    = 0;

    // 3: output back-pressure toggling every cycle on a 10-byte frame.
    toggle_en      = 1;
    stall_check_en = 1;
    push_frame(1, 10, 8'h60, 1'b0);
    send_frame(1, 10, 10, 8'h60, 1'b0);
    wait_idle("t3_idle");
    toggle_en      = 0;
    stall_check_en = 0;
    repeat (2) @(posedge clk);
    #1;

    // 6: bad-frame flag on the last beat only.
    push_frame(1, 8, 8'hD0, 1'b1);
    send_frame(1, 8, 8, 8'hD0, 1'b1);
    wait_idle("t6_idle");

`ifdef ETH_TX_ARB_MAXLEN_EN
    // 5: 20-byte frame on port 2 cut at 16 bytes, tail consumed silently.
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{data: 8'h20 + 8'(i), last: (i == 15), user: (i == 15)});
    fd_q.push_back(2);
    trunc_exp = 1;
    send_frame(2, 20, 20, 8'h20, 1'b0);
    wait_idle("t5_idle");
    check("t5_truncated_seen", trunc_exp, 0);
`endif

    // 4: reset after byte 5 of a 20-byte frame on port 3, then port 0 wins over port 3.
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{data: 8'hA0 + 8'(i), last: 1'b0, user: 1'b0});
    send_frame(3, 20, 5, 8'hA0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t4_rst_m_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("t4_rst_s_tready", {28'd0, s_axis_tready}, 0);
    check("t4_rst_grant_active", {31'd0, grant_active}, 0);
    rst = 1'b0;
    push_frame(0, 3, 8'h10, 1'b0);
    push_frame(3, 3, 8'h30, 1'b0);
    fork
      send_frame(0, 3, 3, 8'h10, 1'b0);
      send_frame(3, 3, 3, 8'h30, 1'b0);
    join
    wait_idle("t4_idle");

    check("exp_queue_drained", exp_q.size(), 0);
    check("frame_done_queue_drained", fd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule
